// File: rtl/if_id_fetch.sv
// ---------------------------------------------------------------------------
// if_id_fetch
//   Instruction fetch stage plus the IF/ID pipeline register.
//
//   The PC drives the instruction memory address directly. A small FSM adds
//   one BOOT cycle after reset, which loads a bubble into IF/ID. After that
//   the FSM tracks whether the hazard unit is holding the PC (HOLD) or not
//   (RUN). A 16-bit saturating counter records the number of stalled cycles.
//
// Ports
//   clk            : sole clock, rising edge
//   rst_n          : asynchronous active-low reset
//   pc_write       : 1 = PC advances or redirects, 0 = PC holds
//   if_id_write    : 1 = IF/ID loads, 0 = IF/ID holds (wins over flush)
//   if_id_flush    : load a bubble instead of the fetched word
//   redirect_valid : taken branch/jump resolved in ID this cycle
//   redirect_pc    : target address used with redirect_valid
//   imem_addr      : instruction memory address (the PC)
//   imem_rdata     : combinational read data for imem_addr
//   if_id_instr    : registered instruction word sent to ID
//   if_id_pc4      : registered PC+4 of that instruction
//   if_id_valid    : IF/ID holds a real instruction
//   stall_cnt      : saturating count of pc_write=0 cycles in RUN/HOLD
//   fsm_state      : debug view of the FSM (0 BOOT, 1 RUN, 2 HOLD)
//
// Handshake: this stage has no valid/ready pair. The hazard unit owns flow
// control through pc_write and if_id_write. Each enable acts alone, with no
// cross-check. if_id_valid only marks bubbles, so ID must not treat it as a
// request that needs an acknowledgement.
// ---------------------------------------------------------------------------
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [15:0] stall_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] instr_nxt;
  logic [31:0] pc4_nxt;
  logic        valid_nxt;
  logic [15:0] cnt_nxt;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;   // 32-bit modulo: FFFF_FFFC wraps to 0
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      stall_cnt   <= 16'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
      stall_cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    pc4_nxt   = if_id_pc4;
    valid_nxt = if_id_valid;
    cnt_nxt   = stall_cnt;

    case (state)
      BOOT: begin
        // The PC holds, so the first real fetch happens from RESET_PC.
        state_nxt = RUN;
        instr_nxt = NOP_WORD;
        pc4_nxt   = 32'd0;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = pc_write ? RUN : HOLD;

        if (pc_write) begin
          // The delay slot means a redirect only retargets the PC. The word
          // fetched this cycle still enters IF/ID.
          pc_nxt = redirect_valid ? redirect_pc : pc_plus4;
        end else if (stall_cnt != 16'hFFFF) begin
          // A stalled redirect is dropped; ID re-asserts it later.
          cnt_nxt = stall_cnt + 16'd1;
        end

        if (if_id_write) begin
          instr_nxt = if_id_flush ? NOP_WORD : imem_rdata;
          pc4_nxt   = pc_plus4;
          valid_nxt = !if_id_flush;
        end
      end
    endcase
  end

endmodule
